// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline hazard/stall control slice:
// the busy-state encoding, the hard-wired zero register and default parameters.
package mips_pipe_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } busy_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int MULDIV_LATENCY_DEF = 4;
  localparam int CNT_WIDTH_DEF      = 32;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Bundle of ID/EX/MEM hazard inputs and stall/flush outputs between the
// datapath (master) and the hazard controller (slave).
interface hazard_stall_ctrl_if #(
  parameter int CNT_WIDTH = 32
) ();

  logic [4:0]           IFID_Rs;
  logic [4:0]           IFID_Rt;
  logic                 IFID_UsesRt;
  logic                 IFID_IsBranch;
  logic                 IFID_ReadsHiLo;
  logic                 IFID_IsMulDiv;
  logic                 Branch_Taken;
  logic                 IDEX_MemRead;
  logic                 IDEX_RegWrite;
  logic [4:0]           IDEX_Rd;
  logic                 EXMEM_MemRead;
  logic [4:0]           EXMEM_Rd;
  logic                 MulDiv_Start;

  logic                 Stall_PC;
  logic                 Stall_IFID;
  logic                 Flush_IFID;
  logic                 Bubble_IDEX;
  logic                 MulDiv_Busy;
  logic [CNT_WIDTH-1:0] StallCount;

  modport master (
    output IFID_Rs, IFID_Rt, IFID_UsesRt, IFID_IsBranch, IFID_ReadsHiLo,
           IFID_IsMulDiv, Branch_Taken, IDEX_MemRead, IDEX_RegWrite, IDEX_Rd,
           EXMEM_MemRead, EXMEM_Rd, MulDiv_Start,
    input  Stall_PC, Stall_IFID, Flush_IFID, Bubble_IDEX, MulDiv_Busy,
           StallCount
  );

  modport slave (
    input  IFID_Rs, IFID_Rt, IFID_UsesRt, IFID_IsBranch, IFID_ReadsHiLo,
           IFID_IsMulDiv, Branch_Taken, IDEX_MemRead, IDEX_RegWrite, IDEX_Rd,
           EXMEM_MemRead, EXMEM_Rd, MulDiv_Start,
    output Stall_PC, Stall_IFID, Flush_IFID, Bubble_IDEX, MulDiv_Busy,
           StallCount
  );

endinterface

// File: rtl/muldiv_busy_tracker.sv
// Tracks an in-flight mult/div: busy for MULDIV_LATENCY-1 cycles after the
// issue pulse, restarting the count on every new issue.
module muldiv_busy_tracker
  import mips_pipe_pkg::*;
#(
  parameter int MULDIV_LATENCY = MULDIV_LATENCY_DEF
) (
  input  logic Clk,
  input  logic Reset,
  input  logic MulDiv_Start,
  output logic MulDiv_Busy
);

  localparam logic [3:0] RELOAD = 4'(MULDIV_LATENCY - 1);

  busy_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt holds the busy cycles still to go; BUSY is left on the edge it hits zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (MulDiv_Start && (MULDIV_LATENCY > 1)) begin
          state_d = BUSY;
          cnt_d   = RELOAD;
        end
      end
      BUSY: begin
        if (MulDiv_Start) begin
          cnt_d = RELOAD;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_d == 4'd0) state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign MulDiv_Busy = (state_q == BUSY);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush generator: load-use, ID-branch operand and HI/LO
// hazards, plus a wrapping count of stalled cycles.
module hazard_stall_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int MULDIV_LATENCY = MULDIV_LATENCY_DEF,
  parameter int CNT_WIDTH      = CNT_WIDTH_DEF
) (
  input  logic          Clk,
  input  logic          Reset,
  hazard_stall_ctrl_if.slave bus
);

  logic                 busy_raw;
  logic                 cmp_rt;
  logic                 h_load, h_br, h_md;
  logic                 stall;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic use_rt);
    return (rd != REG_ZERO) && ((rd == rs) || (use_rt && (rd == rt)));
  endfunction

  muldiv_busy_tracker #(
    .MULDIV_LATENCY(MULDIV_LATENCY)
  ) u_busy (
    .Clk         (Clk),
    .Reset       (Reset),
    .MulDiv_Start(bus.MulDiv_Start),
    .MulDiv_Busy (busy_raw)
  );

  // Branches resolve in ID, so they always depend on both source operands.
  assign cmp_rt = bus.IFID_UsesRt | bus.IFID_IsBranch;

  assign h_load = bus.IDEX_MemRead &
                  reg_match(bus.IDEX_Rd, bus.IFID_Rs, bus.IFID_Rt, cmp_rt);
  assign h_br   = bus.IFID_IsBranch &
                  ((bus.IDEX_RegWrite &
                    reg_match(bus.IDEX_Rd, bus.IFID_Rs, bus.IFID_Rt, cmp_rt)) |
                   (bus.EXMEM_MemRead &
                    reg_match(bus.EXMEM_Rd, bus.IFID_Rs, bus.IFID_Rt, cmp_rt)));
  assign h_md   = busy_raw & (bus.IFID_ReadsHiLo | bus.IFID_IsMulDiv);

  assign stall  = ~Reset & (h_load | h_br | h_md);

  always_comb begin
    count_d = count_q;
    if (stall) count_d = count_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge Clk) begin
    if (Reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign bus.Stall_PC    = stall;
  assign bus.Stall_IFID  = stall;
  assign bus.Bubble_IDEX = stall;
  // A stalled branch compared stale operands, so its taken flag is not trusted.
  assign bus.Flush_IFID  = ~Reset & bus.Branch_Taken & ~stall;
  assign bus.MulDiv_Busy = ~Reset & busy_raw;
  assign bus.StallCount  = Reset ? '0 : count_q;

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Producer of the pipeline stall/flush controls for the 5-stage MIPS datapath; drives Stall_PC (the PC-increment hold input) plus IF/ID hold, IF/ID flush and ID/EX bubble.
- Detects load-use hazards, branch-operand hazards (branches compare in ID) and multiply/divide result hazards.
- Multiply/divide hazards are tracked by an internal busy FSM with a latency counter.
- Also keeps a free-running count of stall cycles for performance measurement.

Parameters:
- MULDIV_LATENCY, 4, cycles from MulDiv_Start until HI/LO is valid (1..15).
- CNT_WIDTH, 32, width of StallCount.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- IFID_Rs  in  5  rs field of the instruction in ID.
- IFID_Rt  in  5  rt field of the instruction in ID.
- IFID_UsesRt  in  1  ID instruction reads rt as a source.
- IFID_IsBranch  in  1  ID instruction is beq/bne/etc (compares in ID).
- IFID_ReadsHiLo  in  1  ID instruction is mfhi/mflo.
- IFID_IsMulDiv  in  1  ID instruction is mult/div.
- Branch_Taken  in  1  ID branch/jump resolves taken this cycle.
- IDEX_MemRead  in  1  EX-stage instruction is a load.
- IDEX_RegWrite  in  1  EX-stage instruction writes a register.
- IDEX_Rd  in  5  final destination register of the EX-stage instruction.
- EXMEM_MemRead  in  1  MEM-stage instruction is a load.
- EXMEM_Rd  in  5  destination register of the MEM-stage instruction.
- MulDiv_Start  in  1  one-cycle pulse: mult/div issued into EX this cycle.
- Stall_PC  out  1  hold PC (PC+4 path outputs PC unchanged).
- Stall_IFID  out  1  hold the IF/ID register.
- Flush_IFID  out  1  zero the IF/ID register next edge.
- Bubble_IDEX  out  1  load a NOP into ID/EX next edge.
- MulDiv_Busy  out  1  HI/LO result not yet valid.
- StallCount  out  CNT_WIDTH  number of cycles with Stall_PC=1 since reset.

Behaviour:
- Matching rule: a register match requires Rd != 0. Rt is compared only when IFID_UsesRt=1, except branches, which always compare both Rs and Rt.
- Hazard terms:
  - H_load = IDEX_MemRead & match(IDEX_Rd).
  - H_br = IFID_IsBranch & ((IDEX_RegWrite & match(IDEX_Rd)) | (EXMEM_MemRead & match(EXMEM_Rd))).
  - H_md = MulDiv_Busy & (IFID_ReadsHiLo | IFID_IsMulDiv).
- Stall = H_load | H_br | H_md.
- Stall_PC = Stall_IFID = Bubble_IDEX = Stall. These are combinational in the same cycle from inputs and state, with no registered latency.
- Flush_IFID = Branch_Taken & ~Stall. A stalled branch is evaluating stale operands, so its taken flag is ignored until the stall clears.
- A load-then-branch dependency stalls 2 cycles: H_load, then H_br via EXMEM_MemRead.
- Busy FSM states:
  - IDLE: MulDiv_Busy=0. On MulDiv_Start, load cnt=MULDIV_LATENCY-1 and go to BUSY. If MULDIV_LATENCY=1, stay in IDLE.
  - BUSY: MulDiv_Busy=1; cnt decrements every cycle, stall or not. At cnt==0 go to IDLE next edge.
  - MulDiv_Start while in BUSY reloads cnt=MULDIV_LATENCY-1 and stays in BUSY.
- StallCount increments by 1 on each edge where Stall_PC=1. It wraps modulo 2^CNT_WIDTH and never saturates.
- Reset (synchronous, sampled on the edge):
  - FSM goes to IDLE, cnt=0, StallCount=0.
  - All outputs read 0 while Reset=1, regardless of the hazard inputs.
  - A Reset asserted mid-BUSY abandons the operation; MulDiv_Busy=0 on the following cycle.

Decomposition:
- Shared package mips_pipe_pkg holds:
  - busy-state encoding IDLE=1'b0, BUSY=1'b1;
  - the register-zero constant REG_ZERO=5'd0;
  - the default MULDIV_LATENCY.
- One sub-module: muldiv_busy_tracker, containing the FSM and counter, with ports Clk, Reset, MulDiv_Start and MulDiv_Busy.

Test Plan:
- Load-use: IDEX_MemRead=1, IDEX_Rd=8, IFID_Rs=8 -> Stall_PC=Stall_IFID=Bubble_IDEX=1 for exactly 1 cycle; StallCount 0->1. Same case with IDEX_Rd=0 -> no stall.
- Rt use: IDEX_Rd=9, IFID_Rt=9, IFID_UsesRt=0, no branch -> no stall. Set IFID_UsesRt=1 -> stall.
- Branch after load on $t0: cycle n H_load, cycle n+1 EXMEM_MemRead/Rd=8 -> H_br. Total 2 stall cycles; Branch_Taken=1 throughout gives Flush_IFID=0 for both, then 1 on the first unstalled cycle.
- MulDiv with MULDIV_LATENCY=4: MulDiv_Start at cycle 0, IFID_ReadsHiLo=1 from cycle 1 -> MulDiv_Busy=1 for cycles 1-3, stall cycles 1-3, release at cycle 4. Repeat with MulDiv_Start re-pulsed at cycle 2 -> busy through cycle 5.
- Reset mid-BUSY: assert Reset at cycle 2 of a mult -> all outputs 0 during Reset; after release MulDiv_Busy=0 and StallCount=0.
- Wrap: CNT_WIDTH=4, hold a stall for 17 cycles -> StallCount reads 1.
